updown_counter_param: RTL and testbench

Parametrised binary counter for timers, dividers and address generators.
- Width and modulus are parameters; direction, enable, synchronous clear and parallel load are runtime inputs.
- End-of-range behaviour is either wrap-around or saturation, selected by parameter.
- Outputs: registered count, terminal-count indication, event pulse and sticky overflow flag.

---
 rtl/counter_pkg.sv | 18 +
 rtl/counter_next_calc.sv | 46 ++++
 rtl/updown_counter_param.sv | 72 +++++++
 tb/tb_updown_counter_param.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/counter_pkg.sv
// Shared constants and helpers for the parametrised up/down counter.
// Import with: import counter_pkg::*;
package counter_pkg;

    localparam int CNT_MODE_WRAP = 0;
    localparam int CNT_MODE_SAT  = 1;

    // Smallest width (at least 1) that can hold 0..modulus-1.
    function automatic int cnt_width(input int modulus);
        int w;
        w = 1;
        for (int i = 1; i < 31; i++) begin
            if ((1 << i) < modulus) w = i + 1;
        end
        return w;
    endfunction

endpackage

// File: rtl/counter_next_calc.sv
// Combinational step, range-end detection and load clamp.
// Arithmetic is carried in WIDTH+1 bits so MODULUS < 2**WIDTH never aliases.
module counter_next_calc
    import counter_pkg::*;
#(
    parameter int WIDTH    = 8,
    parameter int MODULUS  = 2 ** WIDTH,
    parameter int SATURATE = CNT_MODE_WRAP
) (
    input  logic [WIDTH-1:0] q,
    input  logic             up_dn,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] step_val,
    output logic             end_hit,
    output logic [WIDTH-1:0] load_clamped
);

    localparam logic [WIDTH:0]   MOD_W = (WIDTH + 1)'(MODULUS);
    localparam logic [WIDTH:0]   ONE_W = (WIDTH + 1)'(1);
    localparam logic [WIDTH-1:0] MAX_V = WIDTH'(MODULUS - 1);
    localparam logic             SAT   = (SATURATE == CNT_MODE_SAT);

    logic [WIDTH:0] inc;
    logic [WIDTH:0] dec;
    logic           hit_up;
    logic           hit_dn;

    always_comb begin
        inc    = {1'b0, q} + ONE_W;
        dec    = {1'b0, q} - ONE_W;
        hit_up = (inc == MOD_W);
        // Borrow out of the extended subtract means q was zero.
        hit_dn = dec[WIDTH];

        if (up_dn) begin
            end_hit  = hit_up;
            step_val = hit_up ? (SAT ? q : '0) : inc[WIDTH-1:0];
        end else begin
            end_hit  = hit_dn;
            step_val = hit_dn ? (SAT ? q : MAX_V) : dec[WIDTH-1:0];
        end

        load_clamped = ({1'b0, load_val} >= MOD_W) ? MAX_V : load_val;
    end

endmodule

// File: rtl/updown_counter_param.sv
// Parametrised up/down counter: wrap or saturate, load, clear,
// terminal count, end-event pulse and sticky overflow.
module updown_counter_param
    import counter_pkg::*;
#(
    parameter int WIDTH     = 8,
    parameter int MODULUS   = 2 ** WIDTH,
    parameter int SATURATE  = CNT_MODE_WRAP,
    parameter int RESET_VAL = 0
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             en,
    input  logic             up_dn,
    input  logic             clr,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] q_out,
    output logic             tc,
    output logic             evt,
    output logic             ovf
);

    localparam logic [WIDTH-1:0] RST_Q = WIDTH'(RESET_VAL);
    localparam logic [WIDTH-1:0] MAX_Q = WIDTH'(MODULUS - 1);

    if (WIDTH < 1 || MODULUS < 2 || MODULUS > 2 ** WIDTH ||
        RESET_VAL < 0 || RESET_VAL >= MODULUS) begin : g_bad_params
        $fatal(1, "updown_counter_param: illegal WIDTH/MODULUS/RESET_VAL");
    end

    logic [WIDTH-1:0] step_val;
    logic [WIDTH-1:0] load_clamped;
    logic             end_hit;

    counter_next_calc #(
        .WIDTH    (WIDTH),
        .MODULUS  (MODULUS),
        .SATURATE (SATURATE)
    ) u_next (
        .q            (q_out),
        .up_dn        (up_dn),
        .load_val     (load_val),
        .step_val     (step_val),
        .end_hit      (end_hit),
        .load_clamped (load_clamped)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            q_out <= RST_Q;
            evt   <= 1'b0;
            ovf   <= 1'b0;
        end else if (clr) begin
            q_out <= RST_Q;
            evt   <= 1'b0;
            ovf   <= 1'b0;
        end else if (load) begin
            q_out <= load_clamped;
            evt   <= 1'b0;
        end else if (en) begin
            q_out <= step_val;
            evt   <= end_hit;
            if (end_hit) ovf <= 1'b1;
        end else begin
            evt   <= 1'b0;
        end
    end

    assign tc = up_dn ? (q_out == MAX_Q) : (q_out == '0);

endmodule

// File: tb/tb_updown_counter_param.sv
// Directed bench: three counter configurations driven from shared inputs,
// each scenario task checks the instance it targets.
module tb_updown_counter_param;
    import counter_pkg::*;

    localparam int WA = cnt_width(10);
    localparam int WC = cnt_width(8);

    logic          clk = 1'b0;
    logic          reset_n;
    logic          en;
    logic          up_dn;
    logic          clr;
    logic          load;
    logic [WA-1:0] load_val;

    logic [WA-1:0] qa, qb;
    logic [WC-1:0] qc;
    logic          tca, evta, ovfa;
    logic          tcb, evtb, ovfb;
    logic          tcc, evtc, ovfc;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    updown_counter_param #(
        .WIDTH(WA), .MODULUS(10), .SATURATE(CNT_MODE_WRAP), .RESET_VAL(0)
    ) dut_a (
        .clk(clk), .reset_n(reset_n), .en(en), .up_dn(up_dn),
        .clr(clr), .load(load), .load_val(load_val),
        .q_out(qa), .tc(tca), .evt(evta), .ovf(ovfa)
    );

    updown_counter_param #(
        .WIDTH(WA), .MODULUS(10), .SATURATE(CNT_MODE_SAT), .RESET_VAL(0)
    ) dut_b (
        .clk(clk), .reset_n(reset_n), .en(en), .up_dn(up_dn),
        .clr(clr), .load(load), .load_val(load_val),
        .q_out(qb), .tc(tcb), .evt(evtb), .ovf(ovfb)
    );

    updown_counter_param #(
        .WIDTH(WC)
    ) dut_c (
        .clk(clk), .reset_n(reset_n), .en(en), .up_dn(up_dn),
        .clr(clr), .load(load), .load_val(load_val[WC-1:0]),
        .q_out(qc), .tc(tcc), .evt(evtc), .ovf(ovfc)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset_n = 1'b0; en = 1'b0; up_dn = 1'b1;
        clr = 1'b0; load = 1'b0; load_val = '0;
        #2;
        n_checks++;
        if (qa !== 4'd0) begin
            n_fail++; $display("FAIL reset_q got %0d want 0", qa);
        end
        n_checks++;
        if (evta !== 1'b0 || ovfa !== 1'b0) begin
            n_fail++; $display("FAIL reset_flags got evt=%b ovf=%b want 0 0", evta, ovfa);
        end
        n_checks++;
        if (tca !== 1'b0) begin
            n_fail++; $display("FAIL reset_tc_up got %b want 0", tca);
        end
        n_checks++;
        if (qc !== 3'd0 || ovfc !== 1'b0) begin
            n_fail++; $display("FAIL reset_c got q=%0d ovf=%b want 0 0", qc, ovfc);
        end
        up_dn = 1'b0;
        #1;
        n_checks++;
        if (tca !== 1'b1) begin
            n_fail++; $display("FAIL reset_tc_dn got %b want 1", tca);
        end
        @(negedge clk);
        reset_n = 1'b1;
        up_dn   = 1'b1;
        step();
        n_checks++;
        if (qa !== 4'd0 || evta !== 1'b0) begin
            n_fail++; $display("FAIL idle_hold got q=%0d evt=%b want 0 0", qa, evta);
        end
    endtask

    task automatic test_wrap_up();
        logic [3:0] exp_q;
        en = 1'b1; up_dn = 1'b1;
        for (int i = 1; i <= 12; i++) begin
            step();
            exp_q = 4'(i % 10);
            n_checks++;
            if (qa !== exp_q || evta !== (i == 10) || ovfa !== (i >= 10) ||
                tca !== (exp_q == 4'd9)) begin
                n_fail++;
                $display("FAIL wrap_up[%0d] got q=%0d evt=%b ovf=%b tc=%b want q=%0d evt=%b ovf=%b tc=%b",
                         i, qa, evta, ovfa, tca, exp_q, (i == 10), (i >= 10), (exp_q == 4'd9));
            end
        end
        en = 1'b0;
    endtask

    task automatic test_load_down();
        logic [3:0] exp_seq [5];
        exp_seq = '{4'd2, 4'd1, 4'd0, 4'd9, 4'd8};
        load = 1'b1; load_val = 4'd3; en = 1'b1; up_dn = 1'b1;
        step();
        load = 1'b0;
        n_checks++;
        if (qa !== 4'd3 || evta !== 1'b0 || ovfa !== 1'b1) begin
            n_fail++;
            $display("FAIL load3 got q=%0d evt=%b ovf=%b want 3 0 1", qa, evta, ovfa);
        end
        up_dn = 1'b0;
        for (int k = 0; k < 5; k++) begin
            step();
            n_checks++;
            if (qa !== exp_seq[k] || evta !== (k == 3) || tca !== (exp_seq[k] == 4'd0)) begin
                n_fail++;
                $display("FAIL down[%0d] got q=%0d evt=%b tc=%b want q=%0d evt=%b tc=%b",
                         k, qa, evta, tca, exp_seq[k], (k == 3), (exp_seq[k] == 4'd0));
            end
        end
        en = 1'b0;
    endtask

    task automatic test_rollover_w3();
        logic [2:0] exp_q;
        clr = 1'b1;
        step();
        clr = 1'b0;
        n_checks++;
        if (qc !== 3'd0 || ovfc !== 1'b0) begin
            n_fail++; $display("FAIL w3_clr got q=%0d ovf=%b want 0 0", qc, ovfc);
        end
        en = 1'b1; up_dn = 1'b1;
        for (int i = 1; i <= 9; i++) begin
            step();
            exp_q = 3'(i % 8);
            n_checks++;
            if (qc !== exp_q || evtc !== (i == 8) || ovfc !== (i >= 8)) begin
                n_fail++;
                $display("FAIL w3_up[%0d] got q=%0d evt=%b ovf=%b want q=%0d evt=%b ovf=%b",
                         i, qc, evtc, ovfc, exp_q, (i == 8), (i >= 8));
            end
        end
        en = 1'b0;
    endtask

    task automatic test_saturate();
        clr = 1'b1;
        step();
        clr = 1'b0; load = 1'b1; load_val = 4'd8;
        step();
        load = 1'b0;
        n_checks++;
        if (qb !== 4'd8 || ovfb !== 1'b0) begin
            n_fail++; $display("FAIL sat_load got q=%0d ovf=%b want 8 0", qb, ovfb);
        end
        en = 1'b1; up_dn = 1'b1;
        for (int k = 0; k < 4; k++) begin
            step();
            n_checks++;
            if (qb !== 4'd9 || evtb !== (k > 0) || ovfb !== (k > 0) || tcb !== 1'b1) begin
                n_fail++;
                $display("FAIL sat_up[%0d] got q=%0d evt=%b ovf=%b tc=%b want q=9 evt=%b ovf=%b tc=1",
                         k, qb, evtb, ovfb, tcb, (k > 0), (k > 0));
            end
        end
        en = 1'b0;
        step();
        n_checks++;
        if (qb !== 4'd9 || evtb !== 1'b0 || ovfb !== 1'b1) begin
            n_fail++;
            $display("FAIL sat_idle got q=%0d evt=%b ovf=%b want 9 0 1", qb, evtb, ovfb);
        end
    endtask

    task automatic test_clamp_priority();
        load = 1'b1; load_val = 4'd12;
        step();
        load = 1'b0;
        n_checks++;
        if (qa !== 4'd9 || qb !== 4'd9) begin
            n_fail++; $display("FAIL clamp got a=%0d b=%0d want 9 9", qa, qb);
        end
        en = 1'b1; up_dn = 1'b1;
        step();
        n_checks++;
        if (qa !== 4'd0 || ovfa !== 1'b1 || evta !== 1'b1) begin
            n_fail++;
            $display("FAIL clamp_wrap got q=%0d ovf=%b evt=%b want 0 1 1", qa, ovfa, evta);
        end
        clr = 1'b1; load = 1'b1; load_val = 4'd5;
        step();
        clr = 1'b0; load = 1'b0;
        n_checks++;
        if (qa !== 4'd0 || ovfa !== 1'b0 || evta !== 1'b0 || qb !== 4'd0 || ovfb !== 1'b0) begin
            n_fail++;
            $display("FAIL clr_prio got a=%0d ovf=%b evt=%b b=%0d ovfb=%b want 0 0 0 0 0",
                     qa, ovfa, evta, qb, ovfb);
        end
        en = 1'b0;
    endtask

    task automatic test_async_reset();
        load = 1'b1; load_val = 4'd9;
        step();
        load = 1'b0; en = 1'b1; up_dn = 1'b1;
        for (int k = 0; k < 7; k++) step();
        n_checks++;
        if (qa !== 4'd6 || ovfa !== 1'b1) begin
            n_fail++; $display("FAIL pre_reset got q=%0d ovf=%b want 6 1", qa, ovfa);
        end
        #2;
        reset_n = 1'b0;
        #1;
        n_checks++;
        if (qa !== 4'd0 || ovfa !== 1'b0 || evta !== 1'b0) begin
            n_fail++;
            $display("FAIL async_reset got q=%0d ovf=%b evt=%b want 0 0 0", qa, ovfa, evta);
        end
        step();
        n_checks++;
        if (qa !== 4'd0) begin
            n_fail++; $display("FAIL reset_held got q=%0d want 0", qa);
        end
        @(negedge clk);
        reset_n = 1'b1;
        step();
        n_checks++;
        if (qa !== 4'd1 || ovfa !== 1'b0) begin
            n_fail++; $display("FAIL resume got q=%0d ovf=%b want 1 0", qa, ovfa);
        end
        up_dn = 1'b0;
        step();
        n_checks++;
        if (qa !== 4'd0 || tca !== 1'b1) begin
            n_fail++; $display("FAIL dir_change got q=%0d tc=%b want 0 1", qa, tca);
        end
        en = 1'b0;
    endtask

    initial begin
        test_reset();
        test_wrap_up();
        test_load_down();
        test_rollover_w3();
        test_saturate();
        test_clamp_priority();
        test_async_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
